// File: rtl/snail_pkg.sv
// rtl/snail_pkg.sv - shared types and defaults for the snail sequencing controller
package snail_pkg;

  localparam int W_DEFAULT  = 16;
  localparam int CW_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CW{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/snail_seq_ctrl.sv
// rtl/snail_seq_ctrl.sv - shifts a captured word into the snail detector and counts detections
module snail_seq_ctrl
  import snail_pkg::*;
#(
  parameter int  W  = W_DEFAULT,
  parameter int  CW = CW_DEFAULT,
  localparam int LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          det_rst,
  output logic          in_seq,
  input  logic          moore_y,
  input  logic          mealy_y,
  output logic [CW-1:0] moore_cnt,
  output logic [CW-1:0] mealy_cnt
);

  state_t        state_q, state_d;
  logic [W-1:0]  pattern_q, pattern_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_clamp;
  logic [LW-1:0] bit_sel;
  logic          sel_bit;
  logic          cnt_clr;
  logic          moore_inc;
  logic          mealy_inc;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_clr   = 1'b0;
    moore_inc = 1'b0;
    mealy_inc = 1'b0;
    len_clamp = (len > LW'(W)) ? LW'(W) : len;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_clamp != '0) begin
            pattern_d = pattern;
            len_d     = len_clamp;
            idx_d     = '0;
            state_d   = CLEAR;
          end else begin
            cnt_clr = 1'b1;
            state_d = DONE;
          end
        end
      end
      CLEAR: begin
        cnt_clr = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Moore lags its input by one bit, so the first SHIFT sample is stale
        mealy_inc = mealy_y;
        moore_inc = moore_y && (idx_q != '0);
        idx_d     = idx_q + 1'b1;
        if (idx_q == len_q - 1'b1) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        moore_inc = moore_y;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
    end
  end

  // MSB-first: bit len-1 goes out on the first SHIFT cycle
  always_comb begin
    bit_sel = len_q - idx_q - 1'b1;
    sel_bit = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (bit_sel == LW'(i)) begin
        sel_bit = pattern_q[i];
      end
    end
  end

  assign busy    = (state_q == CLEAR) || (state_q == SHIFT) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign det_rst = (state_q == CLEAR);
  assign in_seq  = (state_q == SHIFT) && sel_bit;

  sat_counter #(.CW(CW)) u_moore_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (moore_inc),
    .count (moore_cnt)
  );

  sat_counter #(.CW(CW)) u_mealy_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (mealy_inc),
    .count (mealy_cnt)
  );

endmodule

// File: tb/tb_snail_seq_ctrl.sv
// tb/tb_snail_seq_ctrl.sv - directed bench for snail_seq_ctrl with a behavioural "01" detector
module tb_snail_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        busy, done, det_rst, in_seq;
  logic [7:0]  moore_cnt, mealy_cnt;
  logic        busy_s, done_s, det_rst_s, in_seq_s;
  logic [1:0]  moore_cnt_s, mealy_cnt_s;
  logic        moore_y, mealy_y;
  logic        prev_q, moore_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  snail_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .busy(busy), .done(done), .det_rst(det_rst), .in_seq(in_seq),
    .moore_y(moore_y), .mealy_y(mealy_y),
    .moore_cnt(moore_cnt), .mealy_cnt(mealy_cnt)
  );

  snail_seq_ctrl #(.W(16), .CW(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .busy(busy_s), .done(done_s), .det_rst(det_rst_s), .in_seq(in_seq_s),
    .moore_y(moore_y), .mealy_y(mealy_y),
    .moore_cnt(moore_cnt_s), .mealy_cnt(mealy_cnt_s)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset || det_rst) begin
      prev_q  <= 1'b1;
      moore_q <= 1'b0;
    end else begin
      prev_q  <= in_seq;
      moore_q <= !prev_q && in_seq;
    end
  end

  assign moore_y = moore_q;
  assign mealy_y = !prev_q && in_seq && !det_rst;

  task automatic issue_start(input logic [15:0] p, input logic [4:0] l);
    pattern = p;
    len     = l;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; pattern = '0; len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, det_rst, in_seq} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0000", {busy, done, det_rst, in_seq});
    end
    checks++;
    if ({moore_cnt, mealy_cnt} !== 16'h0000) begin
      errors++; $display("FAIL reset_counts got=%h exp=0000", {moore_cnt, mealy_cnt});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] p;
    logic exp_busy, exp_done, exp_rst, exp_in;
    p = 16'h0137;
    issue_start(p, 5'd10);
    for (int c = 1; c <= 14; c++) begin
      exp_busy = (c <= 12);
      exp_done = (c == 13);
      exp_rst  = (c == 1);
      exp_in   = (c >= 2 && c <= 11) ? p[11 - c] : 1'b0;
      checks++;
      if ({busy, done, det_rst, in_seq} !== {exp_busy, exp_done, exp_rst, exp_in}) begin
        errors++;
        $display("FAIL basic_cycle c=%0d got busy/done/det_rst/in_seq=%b exp=%b",
                 c, {busy, done, det_rst, in_seq}, {exp_busy, exp_done, exp_rst, exp_in});
      end
      @(negedge clk);
    end
    checks++;
    if (moore_cnt !== 8'd3) begin
      errors++; $display("FAIL basic_moore_cnt got=%0d exp=3", moore_cnt);
    end
    checks++;
    if (mealy_cnt !== 8'd3) begin
      errors++; $display("FAIL basic_mealy_cnt got=%0d exp=3", mealy_cnt);
    end
  endtask

  task automatic test_mid_run_reset;
    int late_done;
    issue_start(16'h0137, 5'd10);
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, in_seq, mealy_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      errors++; $display("FAIL midrst_pre got busy/in_seq/mealy=%b/%b/%0d exp=1/1/1", busy, in_seq, mealy_cnt);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, det_rst, in_seq} !== 4'b0000) begin
      errors++; $display("FAIL midrst_outputs got=%b exp=0000", {busy, done, det_rst, in_seq});
    end
    checks++;
    if ({moore_cnt, mealy_cnt} !== 16'h0000) begin
      errors++; $display("FAIL midrst_counts got=%h exp=0000", {moore_cnt, mealy_cnt});
    end
    @(negedge clk);
    reset = 1'b1;
    late_done = 0;
    for (int c = 0; c < 16; c++) begin
      if (done || busy) late_done++;
      @(negedge clk);
    end
    checks++;
    if (late_done !== 0) begin
      errors++; $display("FAIL midrst_no_done got=%0d active cycles exp=0", late_done);
    end
  endtask

  task automatic test_saturate;
    issue_start(16'h5555, 5'd16);
    repeat (18) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL sat_done got=%b exp=1", done);
    end
    checks++;
    if ({moore_cnt_s, mealy_cnt_s} !== 4'b1111) begin
      errors++; $display("FAIL sat_cw2_counts got=%0d/%0d exp=3/3", moore_cnt_s, mealy_cnt_s);
    end
    checks++;
    if ({moore_cnt, mealy_cnt} !== {8'd8, 8'd8}) begin
      errors++; $display("FAIL sat_cw8_counts got=%0d/%0d exp=8/8", moore_cnt, mealy_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_len_zero;
    issue_start(16'hFFFF, 5'd0);
    checks++;
    if ({done, busy, det_rst} !== 3'b100) begin
      errors++; $display("FAIL len0_cycle1 got done/busy/det_rst=%b exp=100", {done, busy, det_rst});
    end
    checks++;
    if ({moore_cnt, mealy_cnt} !== 16'h0000) begin
      errors++; $display("FAIL len0_counts got=%0d/%0d exp=0/0", moore_cnt, mealy_cnt);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL len0_cycle2 got done/busy=%b exp=00", {done, busy});
    end
  endtask

  task automatic test_back_to_back;
    issue_start(16'h0137, 5'd10);
    repeat (3) @(negedge clk);
    pattern = 16'hFFFF; len = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL ignore_shift got busy/done=%b exp=10", {busy, done});
    end
    repeat (8) @(negedge clk);
    checks++;
    if ({done, moore_cnt, mealy_cnt} !== {1'b1, 8'd3, 8'd3}) begin
      errors++; $display("FAIL ignore_result got done=%b counts=%0d/%0d exp=1 3/3", done, moore_cnt, mealy_cnt);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done, det_rst, moore_cnt, mealy_cnt} !== {3'b000, 8'd3, 8'd3}) begin
      errors++; $display("FAIL ignore_done got busy/done/det_rst=%b counts=%0d/%0d exp=000 3/3",
                         {busy, done, det_rst}, moore_cnt, mealy_cnt);
    end
    issue_start(16'h0001, 5'd20);
    checks++;
    if ({det_rst, busy} !== 2'b11) begin
      errors++; $display("FAIL b2b_clear got det_rst/busy=%b exp=11", {det_rst, busy});
    end
    @(negedge clk);
    checks++;
    if ({moore_cnt, mealy_cnt, in_seq} !== {8'd0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL b2b_cleared got=%0d/%0d in_seq=%b exp=0/0 0", moore_cnt, mealy_cnt, in_seq);
    end
    repeat (15) @(negedge clk);
    checks++;
    if ({in_seq, busy, mealy_cnt} !== {1'b1, 1'b1, 8'd0}) begin
      errors++; $display("FAIL final_last_shift got in_seq/busy=%b mealy=%0d exp=11 0", {in_seq, busy}, mealy_cnt);
    end
    @(negedge clk);
    checks++;
    if ({in_seq, busy, done, moore_cnt, mealy_cnt} !== {3'b010, 8'd0, 8'd1}) begin
      errors++; $display("FAIL final_drain got in_seq/busy/done=%b counts=%0d/%0d exp=010 0/1",
                         {in_seq, busy, done}, moore_cnt, mealy_cnt);
    end
    @(negedge clk);
    checks++;
    if ({done, moore_cnt, mealy_cnt} !== {1'b1, 8'd1, 8'd1}) begin
      errors++; $display("FAIL final_done got done=%b counts=%0d/%0d exp=1 1/1", done, moore_cnt, mealy_cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_run_reset();
    test_saturate();
    test_len_zero();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
